// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller:
// FSM state encoding, decoded memory op, ack timeout and byte-lane constants.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } op_t;

  // Width of the ack wait counter and the count at which a request is abandoned.
  localparam int unsigned       CNT_W       = 8;
  localparam logic [CNT_W-1:0]  ACK_TIMEOUT = 8'd255;

  // Byte-lane enable patterns (bit n enables byte n of the 32-bit word).
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // True for ops that write memory.
  function automatic logic op_is_store(input op_t op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  // Natural-alignment rule: words on 4-byte, halves on 2-byte, bytes anywhere.
  function automatic logic op_aligned(input op_t op, input logic [1:0] byte_addr);
    logic ok;
    case (op)
      OP_LW, OP_SW:         ok = (byte_addr == 2'b00);
      OP_LH, OP_LHU, OP_SH: ok = ~byte_addr[0];
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_steer.sv
// Combinational byte-lane steering: byte enables, replicated store data and
// write strobe for one decoded memory op at a given byte offset.
module mem_lane_steer
  import mem_access_ctrl_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  byte_addr,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        we
);

  // Select lanes and replicate store data so the memory picks the right bytes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    be         = BE_NONE;
    wdata_lane = '0;
    we         = 1'b0;
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        be = BE_WORD;
      end
      OP_SW: begin
        be         = BE_WORD;
        wdata_lane = wdata;
        we         = 1'b1;
      end
      OP_SH: begin
        be         = byte_addr[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_lane = {2{wdata[15:0]}};
        we         = 1'b1;
      end
      OP_SB: begin
        be         = BE_BYTE0 << byte_addr;
        wdata_lane = {4{wdata[7:0]}};
        we         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller. Checks alignment, issues one
// request per instruction, waits (bounded) for the ack, returns the raw load
// word plus its byte offset, and stalls the pipeline while the access is open.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        lw,
  input  logic        lh,
  input  logic        lhu,
  input  logic        lb,
  input  logic        lbu,
  input  logic        sw,
  input  logic        sh,
  input  logic        sb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] rdata_out,
  output logic [1:0]  byteaddr_out,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  state_t           state;
  op_t              op;
  op_t              op_q;
  logic [1:0]       byte_addr_q;
  logic [CNT_W-1:0] wait_cnt;

  logic             has_op;
  logic             aligned;
  logic             start;
  logic [3:0]       steer_be;
  logic [31:0]      steer_wdata;
  logic             steer_we;

  // Collapse the one-hot op strobes into a single encoded op.
  always_comb begin
    op = OP_NONE;
    if      (lw)  op = OP_LW;
    else if (lh)  op = OP_LH;
    else if (lhu) op = OP_LHU;
    else if (lb)  op = OP_LB;
    else if (lbu) op = OP_LBU;
    else if (sw)  op = OP_SW;
    else if (sh)  op = OP_SH;
    else if (sb)  op = OP_SB;
  end

  mem_lane_steer u_lane_steer (
    .op         (op),
    .byte_addr  (addr[1:0]),
    .wdata      (wdata),
    .be         (steer_be),
    .wdata_lane (steer_wdata),
    .we         (steer_we)
  );

  assign has_op  = (op != OP_NONE);
  assign aligned = op_aligned(op, addr[1:0]);
  assign start   = (state == ST_IDLE) && mem_valid && has_op && aligned;

  // Stall must rise in the same cycle the instruction shows up, so it and the
  // address-error / timeout pulses are decoded from state and live inputs.
  always_comb begin
    stall    = start || (state == ST_REQ);
    misalign = (state == ST_IDLE) && mem_valid && has_op && !aligned;
    bus_err  = (state == ST_REQ) && !dm_ack && (wait_cnt == ACK_TIMEOUT);
  end

  // Access FSM with registered request, completion and load-return outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_NONE;
      byte_addr_q  <= 2'b00;
      wait_cnt     <= '0;
      done         <= 1'b0;
      rdata_out    <= '0;
      byteaddr_out <= 2'b00;
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= '0;
      dm_be        <= BE_NONE;
      dm_wdata     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_REQ;
            op_q        <= op;
            byte_addr_q <= addr[1:0];
            wait_cnt    <= '0;
            dm_req      <= 1'b1;
            dm_we       <= steer_we;
            dm_addr     <= {addr[31:2], 2'b00};
            dm_be       <= steer_be;
            dm_wdata    <= steer_wdata;
          end
        end

        ST_REQ: begin
          if (dm_ack) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (!op_is_store(op_q)) begin
              rdata_out    <= dm_rdata;
              byteaddr_out <= byte_addr_q;
            end
          end else if (bus_err) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            rdata_out <= '0;
          end else begin
            wait_cnt <= wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        ST_DONE: begin
          // The pipeline advances this cycle, so never loop back to REQ.
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl plus hand-written
// sequences for timeout, reset-during-request and no-op cycles.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        lw, lh, lhu, lb, lbu, sw, sh, sb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall, done, misalign, bus_err;
  logic [31:0] rdata_out;
  logic [1:0]  byteaddr_out;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .lw           (lw),
    .lh           (lh),
    .lhu          (lhu),
    .lb           (lb),
    .lbu          (lbu),
    .sw           (sw),
    .sh           (sh),
    .sb           (sb),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .done         (done),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .rdata_out    (rdata_out),
    .byteaddr_out (byteaddr_out),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_be        (dm_be),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata)
  );

  // One-hot op codes in the order {lw,lh,lhu,lb,lbu,sw,sh,sb}.
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LW   = 8'b1000_0000;
  localparam logic [7:0] O_LH   = 8'b0100_0000;
  localparam logic [7:0] O_LHU  = 8'b0010_0000;
  localparam logic [7:0] O_LB   = 8'b0001_0000;
  localparam logic [7:0] O_LBU  = 8'b0000_1000;
  localparam logic [7:0] O_SW   = 8'b0000_0100;
  localparam logic [7:0] O_SH   = 8'b0000_0010;
  localparam logic [7:0] O_SB   = 8'b0000_0001;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_after;  // REQ cycle (1-based) carrying dm_ack
    logic [31:0] rdata;
    logic        gap;        // idle cycle after completion
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_daddr;
    logic [31:0] exp_dwd;
    logic        exp_we;
    logic [31:0] exp_rout;
    logic [1:0]  exp_bya;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic [7:0] op, logic [31:0] a, logic [31:0] wd,
                              int ack, logic [31:0] rd, logic gap, logic mis,
                              logic [3:0] be, logic [31:0] da, logic [31:0] dwd,
                              logic we, logic [31:0] rout, logic [1:0] bya);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = wd; v.ack_after = ack; v.rdata = rd;
    v.gap = gap; v.exp_mis = mis; v.exp_be = be; v.exp_daddr = da;
    v.exp_dwd = dwd; v.exp_we = we; v.exp_rout = rout; v.exp_bya = bya;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [7:0] op);
    {lw, lh, lhu, lb, lbu, sw, sh, sb} = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one instruction starting in IDLE, acknowledge on the requested REQ
  // cycle and check request fields, stall length, done pulse and load return.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    int    stall_cycles;
    tag = $sformatf("v%0d", idx);
    step();
    mem_valid = 1'b1;
    drive_op(v.op);
    addr   = v.addr;
    wdata  = v.wdata;
    dm_ack = 1'b0;
    @(negedge clk);
    check({tag, ".idle_done"}, done, 0);
    check({tag, ".misalign"}, misalign, v.exp_mis);
    check({tag, ".stall0"}, stall, !v.exp_mis);
    if (v.exp_mis) begin
      check({tag, ".mis_req"}, dm_req, 0);
      step();
      mem_valid = 1'b0;
      drive_op(O_NONE);
      @(negedge clk);
      check({tag, ".mis_req_next"}, dm_req, 0);
      check({tag, ".mis_stall_next"}, stall, 0);
      check({tag, ".mis_rout"}, rdata_out, v.exp_rout);
      return;
    end
    stall_cycles = 1;
    for (int k = 0; k < v.ack_after; k++) begin
      step();
      dm_ack   = (k == v.ack_after - 1);
      dm_rdata = dm_ack ? v.rdata : 32'h5555_AAAA;
      @(negedge clk);
      if (stall) stall_cycles++;
      if (k == 0 || k == v.ack_after - 1) begin
        check({tag, ".dm_req"}, dm_req, 1);
        check({tag, ".dm_addr"}, dm_addr, v.exp_daddr);
        check({tag, ".dm_be"}, dm_be, v.exp_be);
        check({tag, ".dm_wdata"}, dm_wdata, v.exp_dwd);
        check({tag, ".dm_we"}, dm_we, v.exp_we);
      end
    end
    step();
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    @(negedge clk);
    check({tag, ".done"}, done, 1);
    check({tag, ".done_stall"}, stall, 0);
    check({tag, ".done_req"}, dm_req, 0);
    check({tag, ".bus_err"}, bus_err, 0);
    check({tag, ".stall_cycles"}, stall_cycles, v.ack_after + 1);
    check({tag, ".rdata_out"}, rdata_out, v.exp_rout);
    check({tag, ".byteaddr_out"}, byteaddr_out, v.exp_bya);
    if (v.gap) begin
      step();
      mem_valid = 1'b0;
      drive_op(O_NONE);
      @(negedge clk);
      check({tag, ".gap_done"}, done, 0);
      check({tag, ".gap_req"}, dm_req, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_err;

    //              op     addr        wdata        ack rdata        gap mis be       daddr        dwd          we  rout         bya
    vecs[0]  = mk(O_LW,  32'h100, 32'h0,        3, 32'hDEADBEEF, 1, 0, 4'b1111, 32'h100, 32'h0,        0, 32'hDEADBEEF, 2'b00);
    vecs[1]  = mk(O_SB,  32'h203, 32'h000000A5, 1, 32'h0,        1, 0, 4'b1000, 32'h200, 32'hA5A5A5A5, 1, 32'hDEADBEEF, 2'b00);
    vecs[2]  = mk(O_LH,  32'h101, 32'h0,        0, 32'h0,        1, 1, 4'b0000, 32'h0,   32'h0,        0, 32'hDEADBEEF, 2'b00);
    vecs[3]  = mk(O_SH,  32'h012, 32'h00001234, 2, 32'h0,        0, 0, 4'b1100, 32'h010, 32'h12341234, 1, 32'hDEADBEEF, 2'b00);
    vecs[4]  = mk(O_LW,  32'h014, 32'h0,        1, 32'h0BADF00D, 1, 0, 4'b1111, 32'h014, 32'h0,        0, 32'h0BADF00D, 2'b00);
    vecs[5]  = mk(O_LBU, 32'h043, 32'h0,        2, 32'h11223344, 1, 0, 4'b1111, 32'h040, 32'h0,        0, 32'h11223344, 2'b11);
    vecs[6]  = mk(O_SW,  32'h002, 32'h77777777, 0, 32'h0,        1, 1, 4'b0000, 32'h0,   32'h0,        0, 32'h11223344, 2'b11);
    vecs[7]  = mk(O_LHU, 32'h006, 32'h0,        1, 32'hCAFEF00D, 1, 0, 4'b1111, 32'h004, 32'h0,        0, 32'hCAFEF00D, 2'b10);
    vecs[8]  = mk(O_SW,  32'h300, 32'h89ABCDEF, 4, 32'h0,        1, 0, 4'b1111, 32'h300, 32'h89ABCDEF, 1, 32'hCAFEF00D, 2'b10);
    vecs[9]  = mk(O_SB,  32'h201, 32'h0000005A, 1, 32'h0,        1, 0, 4'b0010, 32'h200, 32'h5A5A5A5A, 1, 32'hCAFEF00D, 2'b10);
    vecs[10] = mk(O_LB,  32'h001, 32'h0,        1, 32'h00000080, 1, 0, 4'b1111, 32'h000, 32'h0,        0, 32'h00000080, 2'b01);
    vecs[11] = mk(O_SH,  32'h020, 32'h0000ABCD, 2, 32'h0,        1, 0, 4'b0011, 32'h020, 32'hABCDABCD, 1, 32'h00000080, 2'b01);
    vecs[12] = mk(O_LH,  32'h003, 32'h0,        0, 32'h0,        1, 1, 4'b0000, 32'h0,   32'h0,        0, 32'h00000080, 2'b01);

    // Reset state.
    rst_n = 1'b0; mem_valid = 1'b0; drive_op(O_NONE);
    addr = '0; wdata = '0; dm_ack = 1'b0; dm_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.stall", stall, 0);
    check("rst.done", done, 0);
    check("rst.dm_req", dm_req, 0);
    check("rst.dm_we", dm_we, 0);
    check("rst.dm_addr", dm_addr, 0);
    check("rst.dm_be", dm_be, 0);
    check("rst.dm_wdata", dm_wdata, 0);
    check("rst.rdata_out", rdata_out, 0);
    check("rst.byteaddr_out", byteaddr_out, 0);
    rst_n = 1'b1;

    // mem_valid without any op: nothing happens.
    step();
    mem_valid = 1'b1;
    dm_ack    = 1'b1;
    @(negedge clk);
    check("noop.stall", stall, 0);
    check("noop.misalign", misalign, 0);
    step();
    mem_valid = 1'b0;
    dm_ack    = 1'b0;
    @(negedge clk);
    check("noop.dm_req", dm_req, 0);
    check("noop.done", done, 0);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Ack timeout: lbu with no ack, bus_err on REQ cycle index 255.
    step();
    mem_valid = 1'b1; drive_op(O_LBU); addr = 32'h42; dm_ack = 1'b0;
    @(negedge clk);
    check("tmo.stall0", stall, 1);
    first_err = -1;
    for (int k = 0; k < 300; k++) begin
      step();
      @(negedge clk);
      if (bus_err) begin
        first_err = k;
        break;
      end
    end
    check("tmo.bus_err_cycle", first_err, 255);
    check("tmo.req_at_err", dm_req, 1);
    check("tmo.stall_at_err", stall, 1);
    step();
    @(negedge clk);
    check("tmo.done", done, 1);
    check("tmo.bus_err_pulse", bus_err, 0);
    check("tmo.rdata_out", rdata_out, 0);
    check("tmo.stall", stall, 0);
    step();
    mem_valid = 1'b0; drive_op(O_NONE);
    @(negedge clk);
    check("tmo.done_once", done, 0);

    // Reset during REQ, then a late ack.
    step();
    mem_valid = 1'b1; drive_op(O_LW); addr = 32'h100;
    @(negedge clk);
    check("rreq.stall0", stall, 1);
    step();
    step();
    rst_n = 1'b0; mem_valid = 1'b0; drive_op(O_NONE);
    @(negedge clk);
    check("rreq.req_before_edge", dm_req, 1);
    step();
    rst_n = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h12345678;
    @(negedge clk);
    check("rreq.dm_req", dm_req, 0);
    check("rreq.done", done, 0);
    check("rreq.stall", stall, 0);
    check("rreq.bus_err", bus_err, 0);
    step();
    @(negedge clk);
    check("rreq.late_done", done, 0);
    check("rreq.late_req", dm_req, 0);
    check("rreq.rdata_out", rdata_out, 0);
    dm_ack = 1'b0; dm_rdata = '0;

    // Controller is back in IDLE and accepts a fresh access.
    run_vec(mk(O_LW, 32'h008, 32'h0, 1, 32'h600DCAFE, 1, 0, 4'b1111, 32'h008, 32'h0,
               0, 32'h600DCAFE, 2'b00), 99);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 mem_valid  input  1  MEM stage holds a memory instruction.
REQ-005 lw, lh, lhu, lb, lbu, sw, sh, sb  input  1 each  decoded op; at most one high.
REQ-006 addr  input  32  effective byte address.
REQ-007 wdata  input  32  unaligned store source (rt value).
REQ-008 stall  output  1  freezes pipeline stages up to MEM.
REQ-009 done  output  1  one-cycle pulse; access complete.
REQ-010 misalign  output  1  address-error pulse, no access made.
REQ-011 bus_err  output  1  one-cycle pulse on ack timeout.
REQ-012 rdata_out  output  32  raw load word for the writeback load extender.
REQ-013 byteaddr_out  output  2  addr[1:0] of the completed load.
REQ-014 dm_req, dm_we  output  1 each  memory request / write strobe.
REQ-015 dm_addr  output  32  {addr[31:2],2'b00}.
REQ-016 dm_be  output  4  byte-lane enables.
REQ-017 dm_wdata  output  32  lane-steered store data.
REQ-018 dm_ack  input  1  memory completion; dm_rdata  input  32  read word, valid with dm_ack.

Function
REQ-019 FSM states SHALL be IDLE, REQ, DONE.
REQ-020 Alignment: lw/sw need addr[1:0]=00; lh/lhu/sh need addr[0]=0; byte ops always aligned.
REQ-021 IDLE, mem_valid, op aligned: stall=1 combinationally; next state REQ; latch dm_addr, dm_we, dm_be, dm_wdata, addr[1:0], op.
REQ-022 IDLE, mem_valid, misaligned: misalign=1 same cycle, stall=0, no dm_req, stay IDLE.
REQ-023 IDLE, mem_valid=0 or no op: stall=0, no action.
REQ-024 REQ: dm_req=1, stall=1; all dm_* outputs stable until dm_ack.
REQ-025 REQ with dm_ack=1: loads register dm_rdata into rdata_out and latched addr[1:0] into byteaddr_out; next DONE.
REQ-026 REQ: 8-bit wait counter cleared on entry; at 255 cycles without ack: bus_err=1 for one cycle, rdata_out=0, next DONE.
REQ-027 DONE: done=1, stall=0, dm_req=0 for exactly one cycle; next IDLE unconditionally (no re-issue of same instruction).
REQ-028 dm_ack outside REQ SHALL be ignored.
REQ-029 Byte enables: lw/lh/lhu/lb/lbu=1111; sw=1111; sh=0011 (addr[1]=0) / 1100 (addr[1]=1); sb=0001<<addr[1:0].
REQ-030 Store data: sw=wdata; sh={2{wdata[15:0]}}; sb={4{wdata[7:0]}}; loads drive 0.
REQ-031 rdata_out and byteaddr_out SHALL hold their value until the next load completion.

Reset
REQ-032 rst_n=0 at a clock edge: state IDLE, counter 0, rdata_out 0, byteaddr_out 00, dm_* registers 0; registered outputs 0 from that edge on.
REQ-033 Reset during REQ SHALL abort silently: no done, no bus_err, and a late dm_ack is ignored.

Structure
REQ-034 Shared package SHALL hold FSM state encoding, ACK_TIMEOUT=255, and byte-enable constants.
REQ-035 Lane steering (REQ-029/030) SHALL be a combinational sub-module mem_lane_steer.

Verification
REQ-036 lw addr=0x100, ack after 3 cycles, dm_rdata=0xDEADBEEF -> stall 4 cycles, dm_be=1111, rdata_out=0xDEADBEEF, done 1 pulse.
REQ-037 sb addr=0x203, wdata=0x000000A5 -> dm_addr=0x200, dm_be=1000, dm_wdata=0xA5A5A5A5, dm_we=1.
REQ-038 lh addr=0x101 -> misalign=1 same cycle, dm_req never asserted, stall=0.
REQ-039 lbu addr=0x42, dm_ack never given -> bus_err at cycle 255 of REQ, rdata_out=0, done pulses.
REQ-040 rst_n=0 during REQ, then dm_ack -> no done, dm_req=0 after reset edge, state IDLE.
REQ-041 Back-to-back sh 0x12 wdata=0x1234, then lw 0x14 -> dm_be 1100 then 1111, two distinct done pulses, no re-issue.
